// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer and the array it drives.
// Holds the default geometry, the sequencer state encoding (as an enum and as
// plain constants for code that keeps state in a raw logic vector), the
// operand/result vector typedefs and a helper that sizes buffer addresses.
package systolic_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 4;
  localparam int DEF_K       = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_FEED  = 3'd2,
    SEQ_WAIT  = 3'd3,
    SEQ_OUT   = 3'd4
  } seq_state_e;

  // Same encoding as seq_state_e, for state registers declared as logic [2:0].
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  typedef logic [DEF_ROWS*DEF_DATA_W-1:0]          act_vec_t;
  typedef logic [DEF_COLS*DEF_DATA_W-1:0]          wgt_vec_t;
  typedef logic [DEF_ROWS*DEF_ACC_W-1:0]           bias_vec_t;
  typedef logic [DEF_ROWS*DEF_COLS*DEF_ACC_W-1:0]  result_mat_t;

  // Address width for a depth-entry buffer; a single-entry buffer still gets 1 bit.
  function automatic int seq_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Bounded wait counter for sequencer-style controllers.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : return the count to 0 (wins over en_i)
//   en_i           : count one cycle
//   tc_o           : high while the count sits at TIMEOUT-1, i.e. on the
//                    TIMEOUT-th enabled cycle after a clear
// The count saturates at the terminal value and never wraps.
module seq_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Runs one matrix-multiply tile through the systolic array: accepts a command,
// reads K activation columns / weight rows from 1-cycle-latency buffers,
// streams them into the array for K consecutive cycles (optionally injecting a
// bias vector on the first), waits for the array's done, captures the result
// and hands it back over a valid/ready handshake.
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset
//   cmd_*                    : tile command (valid/ready, bias enable, bias vector)
//   a_rd_*, b_rd_*           : operand buffer read ports (data one cycle after en)
//   arr_act_*, arr_wgt_*     : operand stream into the array
//   arr_c_data_o/valid_o     : bias injection into the array accumulators
//   arr_result_i, arr_done_i : result matrix and completion from the array
//   res_valid_o/ready_i/data_o : captured result handshake
//   busy_o                   : not idle
//   err_timeout_o            : sticky, array never finished; cleared on next accept
// Vectors are flattened: element i of a vector sits at [i*W +: W], matrix
// element (r,c) at [(r*COLS+c)*ACC_W +: ACC_W].
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int K       = DEF_K,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_bias_en_i,
  input  logic [ROWS*ACC_W-1:0]          cmd_bias_i,
  output logic                           a_rd_en_o,
  output logic [seq_addr_w(K)-1:0]       a_rd_addr_o,
  input  logic [ROWS*DATA_W-1:0]         a_rd_data_i,
  output logic                           b_rd_en_o,
  output logic [seq_addr_w(K)-1:0]       b_rd_addr_o,
  input  logic [COLS*DATA_W-1:0]         b_rd_data_i,
  output logic [ROWS*DATA_W-1:0]         arr_act_col_o,
  output logic                           arr_act_valid_o,
  output logic [COLS*DATA_W-1:0]         arr_wgt_row_o,
  output logic                           arr_wgt_valid_o,
  output logic [ROWS*ACC_W-1:0]          arr_c_data_o,
  output logic [ROWS-1:0]                arr_c_valid_o,
  input  logic [ROWS*COLS*ACC_W-1:0]     arr_result_i,
  input  logic                           arr_done_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [ROWS*COLS*ACC_W-1:0]     res_data_o,
  output logic                           busy_o,
  output logic                           err_timeout_o
);

  localparam int AW = seq_addr_w(K);
  localparam int KW = $clog2(K + 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  logic [2:0]                   state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic                         bias_en_q, bias_en_d;
  logic [ROWS*ACC_W-1:0]        bias_q, bias_d;
  logic [ROWS*COLS*ACC_W-1:0]   res_q, res_d;
  logic                         err_q, err_d;

  logic          in_fetch, in_feed, in_wait, last_feed, wait_tc, bias_cycle;
  logic [KW-1:0] k_plus1;

  assign in_fetch  = (state_q == ST_FETCH);
  assign in_feed   = (state_q == ST_FEED);
  assign in_wait   = (state_q == ST_WAIT);
  assign last_feed = in_feed && (k_q == K_LAST);
  assign k_plus1   = k_q + KW'(1);

  // Counts WAIT cycles; cleared whenever we are elsewhere so every tile starts at 0.
  seq_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (!in_wait),
    .en_i    (in_wait),
    .tc_o    (wait_tc)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bias_en_d = bias_en_q;
    bias_d    = bias_q;
    res_d     = res_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          bias_en_d = cmd_bias_en_i;
          bias_d    = cmd_bias_i;
          err_d     = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        k_d     = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (last_feed) begin
          state_d = ST_WAIT;
        end else begin
          k_d = k_plus1;
        end
      end
      ST_WAIT: begin
        // done on the terminal cycle still counts as a completed tile
        if (arr_done_i) begin
          res_d   = arr_result_i;
          state_d = ST_OUT;
        end else if (wait_tc) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      bias_en_q <= 1'b0;
      bias_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      bias_en_q <= bias_en_d;
      bias_q    <= bias_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  // Reads run one cycle ahead of the feed: FETCH reads entry 0, FEED k reads k+1.
  assign a_rd_en_o   = in_fetch || (in_feed && !last_feed);
  assign b_rd_en_o   = a_rd_en_o;
  assign a_rd_addr_o = in_feed ? k_plus1[AW-1:0] : '0;
  assign b_rd_addr_o = a_rd_addr_o;

  assign arr_act_col_o   = in_feed ? a_rd_data_i : '0;
  assign arr_wgt_row_o   = in_feed ? b_rd_data_i : '0;
  assign arr_act_valid_o = in_feed;
  assign arr_wgt_valid_o = in_feed;

  assign bias_cycle   = in_feed && (k_q == '0) && bias_en_q;
  assign arr_c_data_o = bias_cycle ? bias_q : '0;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_c_valid
    assign arr_c_valid_o[gi] = bias_cycle;
  end

  // Held low while reset is asserted so no command is offered during reset.
  assign cmd_ready_o   = (state_q == ST_IDLE) && !reset_i;
  assign res_valid_o   = (state_q == ST_OUT);
  assign res_data_o    = res_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign err_timeout_o = err_q;

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences one matrix-multiply tile through `systolic_array_top`. It accepts a tile command, reads K activation columns and K weight rows from two synchronous operand buffers, and streams them into the array for K consecutive cycles. It optionally injects a bias vector, waits for the array's `done`, captures the result matrix and returns it over a valid/ready handshake. It sits between the command/buffer layer and the array and owns all array-side valid signalling.

## Interface
- `DATA_W`, 8, operand width
- `ACC_W`, 32, accumulator/result width
- `ROWS`, 4, array rows
- `COLS`, 4, array columns
- `K`, 4, reduction depth (feed cycles per tile), ≥1
- `TIMEOUT`, 64, max cycles in WAIT before error, ≥1

Clock and reset:
- `clk` in 1: single clock, all logic posedge
- `reset` in 1: synchronous, active-high

Command port:
- `cmd_valid` in 1: tile request
- `cmd_ready` out 1: high only in IDLE
- `cmd_bias_en` in 1: inject bias this tile
- `cmd_bias` in [ROWS] x ACC_W: bias vector, sampled at accept

Operand buffers (1-cycle read latency):
- `a_rd_en` out 1
- `a_rd_addr` out $clog2(K) (min 1 bit)
- `a_rd_data` in [ROWS] x DATA_W: activation column k
- `b_rd_en` out 1
- `b_rd_addr` out $clog2(K) (min 1 bit)
- `b_rd_data` in [COLS] x DATA_W: weight row k

Array side:
- `arr_act_col` out [ROWS] x DATA_W
- `arr_act_valid` out 1
- `arr_wgt_row` out [COLS] x DATA_W
- `arr_wgt_valid` out 1
- `arr_c_data` out [ROWS] x ACC_W
- `arr_c_valid` out [ROWS] x 1
- `arr_result` in [ROWS][COLS] x ACC_W
- `arr_done` in 1

Result and status:
- `res_valid` out 1
- `res_ready` in 1
- `res_data` out [ROWS][COLS] x ACC_W
- `busy` out 1: state ≠ IDLE
- `err_timeout` out 1: sticky, cleared on next command accept

## Operation
FSM states are IDLE, FETCH, FEED, WAIT and OUT.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`: latch `cmd_bias_en`/`cmd_bias`, clear `err_timeout`, go to FETCH.
- **FETCH** (1 cycle): assert `a_rd_en`/`b_rd_en`, address 0. Go to FEED.
- **FEED** (exactly K cycles, feed index k=0..K-1):
  - Drive `arr_act_col`=`a_rd_data` and `arr_wgt_row`=`b_rd_data`, combinationally from the buffer outputs.
  - Hold `arr_act_valid`=`arr_wgt_valid`=1 continuously.
  - Issue reads for address k+1 while k<K-1; read enables are 0 on the last FEED cycle.
  - On k=0, if bias latched: `arr_c_valid[r]`=1 for all r, `arr_c_data`=latched bias, for that single cycle only.
  - After k=K-1, go to WAIT.
- **WAIT:**
  - Valids are 0 and the timeout counter increments.
  - First cycle with `arr_done`=1: register `arr_result` into `res_data`, go to OUT.
  - If the counter reaches TIMEOUT without `arr_done`: set `err_timeout`, leave `res_data` unchanged, go to IDLE.
- **OUT:** `res_valid`=1 with `res_data` stable until `res_ready`. On handshake go to IDLE.
- Values are pass-through only; no arithmetic on data. Counters are sized `$clog2(K+1)` and `$clog2(TIMEOUT+1)`, with no wrap inside a tile.

## Timing
- Reset values: all outputs 0 (`cmd_ready`=0 during reset, 1 the cycle after), `res_data`=0, state IDLE, counters 0.
- Reset asserted in any state aborts the tile: next cycle is IDLE and all valids are 0, with no partial result.
- With accept in cycle 0:
  - FETCH is cycle 1.
  - FEED is cycles 2..K+1, with `arr_*_valid` high exactly K consecutive cycles.
  - WAIT starts at K+2.
- Capture latency: `res_valid` rises one cycle after the `arr_done` cycle.
- `arr_done` outside WAIT is ignored.
- `res_ready` pre-asserted in OUT: handshake in the first OUT cycle. `cmd_ready` returns the next cycle, so there is no same-cycle command accept.
- `cmd_valid` outside IDLE is ignored; the command is not queued.

## Structure
- Shared package `systolic_pkg`: `seq_state_e` enum (IDLE/FETCH/FEED/WAIT/OUT), operand/result vector typedefs parameterised by widths, and default constants shared with the array (ROWS/COLS/K/DATA_W/ACC_W).
- No sub-module required. Optional `seq_timeout_counter` (enable, clear, terminal-count output) reusable by other controllers.

## Test plan
- **Identity tile:** K=4, A=identity columns, B rows = 1..16, no bias, model array asserts `arr_done` 10 cycles into WAIT → valids high exactly 4 cycles, `res_data` equals B, `res_valid` one cycle after done.
- **Bias:** `cmd_bias_en`=1, bias={10,20,30,40} → `arr_c_valid` all-ones only on the first FEED cycle with those values; no other cycle.
- **Backpressure:** `res_ready` low 5 cycles in OUT → `res_data` stable, `cmd_ready`=0 throughout; after handshake `cmd_ready`=1 next cycle.
- **Timeout:** TIMEOUT=8, `arr_done` never asserted → IDLE after 8 WAIT cycles, `err_timeout`=1; next accepted command clears it.
- **Reset mid-FEED:** `reset` at k=2 → next cycle IDLE, all valids 0, `res_valid` never asserted.
- **Back-to-back:** two commands with distinct operands → read addresses 0..3 per tile, second `cmd_ready` one cycle after first result handshake, results not mixed.
